// File: rtl/fpu_arbiter_ctrl.sv
// Round-robin sequencer sharing one FP add/sub/mul datapath between two requesters.
// Operands are registered onto the datapath, the result is captured after a settle window.
module fpu_arbiter_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [1:0]  fpu_op,
  output logic [31:0] fpu_para1,
  output logic [31:0] fpu_para2,
  input  logic [31:0] fpu_out,
  input  logic        fpu_under_overflow,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_flag,
  output logic        resp_err,
  output logic        resp_id,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [1:0]  OP_ILLEGAL  = 2'b11;
  localparam logic [31:0] QNAN        = 32'h7FC0_0000;
  localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t      state;
  logic        last_grant;
  logic        grant_id;
  logic        cur_err;
  logic [3:0]  settle_cnt;
  logic        accept;
  logic [1:0]  sel_op;
  logic [31:0] sel_a;
  logic [31:0] sel_b;

  // Grant goes to the sole valid requester, otherwise to the one not served last.
  always_comb begin
    grant_id = ~last_grant;
    if (req0_valid && !req1_valid) begin
      grant_id = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant_id = 1'b1;
    end
  end

  assign req0_ready = (state == IDLE) && !grant_id;
  assign req1_ready = (state == IDLE) &&  grant_id;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign sel_op = grant_id ? req1_op : req0_op;
  assign sel_a  = grant_id ? req1_a  : req0_a;
  assign sel_b  = grant_id ? req1_b  : req0_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cur_err    <= 1'b0;
      settle_cnt <= 4'd0;
      fpu_op     <= 2'b00;
      fpu_para1  <= 32'd0;
      fpu_para2  <= 32'd0;
      resp_valid <= 1'b0;
      resp_data  <= 32'd0;
      resp_flag  <= 1'b0;
      resp_err   <= 1'b0;
      resp_id    <= 1'b0;
      op_count   <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Illegal ops still run the full window, but the datapath sees a harmless add.
            fpu_op     <= (sel_op == OP_ILLEGAL) ? 2'b00 : sel_op;
            fpu_para1  <= sel_a;
            fpu_para2  <= sel_b;
            cur_err    <= (sel_op == OP_ILLEGAL);
            resp_id    <= grant_id;
            last_grant <= grant_id;
            settle_cnt <= SETTLE_LOAD;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (settle_cnt == 4'd0) begin
            resp_data  <= cur_err ? QNAN : fpu_out;
            resp_flag  <= cur_err ? 1'b0 : fpu_under_overflow;
            resp_err   <= cur_err;
            resp_valid <= 1'b1;
            state      <= DONE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            op_count   <= op_count + 16'd1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_arbiter_ctrl.sv
// Scoreboard bench for fpu_arbiter_ctrl: a stand-in datapath model feeds fpu_out,
// accepted requests push expected responses, handshaken responses pop and compare.
module tb_fpu_arbiter_ctrl;

  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  fpu_op;
  logic [31:0] fpu_para1, fpu_para2, fpu_out;
  logic        fpu_under_overflow;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        resp_flag, resp_err, resp_id;
  logic [15:0] op_count;

  typedef struct {
    logic [31:0] data;
    logic        flag;
    logic        err;
    logic        id;
  } exp_t;

  exp_t        exp_q[$];
  logic        grant_log[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  int          exp_count = 0;
  logic        chk_pending = 1'b0;
  logic [1:0]  chk_op;
  logic [31:0] chk_a, chk_b;
  logic        hold_pending = 1'b0;
  logic [63:0] held;
  logic        prev_rv = 1'b0;

  fpu_arbiter_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .fpu_op(fpu_op), .fpu_para1(fpu_para1), .fpu_para2(fpu_para2),
    .fpu_out(fpu_out), .fpu_under_overflow(fpu_under_overflow),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_flag(resp_flag), .resp_err(resp_err), .resp_id(resp_id),
    .op_count(op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Stand-in datapath: exact IEEE results for the known vectors, a scrambled value otherwise.
  function automatic logic [32:0] dpModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 2'b00 && a == 32'h3F800000 && b == 32'h40000000) return {1'b0, 32'h40400000};
    if (op == 2'b01 && a == 32'h40400000 && b == 32'h3F800000) return {1'b0, 32'h40000000};
    if (op == 2'b10 && a == 32'h40000000 && b == 32'h40400000) return {1'b0, 32'h40C00000};
    if (op == 2'b10 && a == 32'h7F7FFFFF && b == 32'h40000000) return {1'b1, 32'h7F800000};
    return {^(a ^ b), a + (b * 32'd3) + 32'(op)};
  endfunction

  always_comb {fpu_under_overflow, fpu_out} = dpModel(fpu_op, fpu_para1, fpu_para2);

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic        id_v;
    logic [1:0]  op_v;
    logic [31:0] a_v, b_v;
    logic [32:0] r;
    checkOutput("both_ready", 64'(req0_ready & req1_ready), 64'd0);
    if (resp_valid) checkOutput("ready_in_done", 64'({req0_ready, req1_ready}), 64'd0);
    checkOutput("op_count", 64'(op_count), 64'(exp_count));
    if (hold_pending && !rst)
      checkOutput("resp_hold", 64'({resp_valid, resp_flag, resp_err, resp_id, resp_data}), held);
    if (rst) begin
      exp_q.delete();
      exp_count    = 0;
      chk_pending  = 1'b0;
      hold_pending = 1'b0;
      prev_rv      = 1'b0;
    end else begin
      if (chk_pending) begin
        checkOutput("fpu_op", 64'(fpu_op), 64'(chk_op));
        checkOutput("fpu_para1", 64'(fpu_para1), 64'(chk_a));
        checkOutput("fpu_para2", 64'(fpu_para2), 64'(chk_b));
        chk_pending = 1'b0;
      end
      if (resp_valid && !prev_rv)
        checkOutput("latency", 64'(cyc - accept_cyc), 64'(SETTLE + 1));
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_resp", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("resp_data", 64'(resp_data), 64'(e.data));
          checkOutput("resp_flag", 64'(resp_flag), 64'(e.flag));
          checkOutput("resp_err", 64'(resp_err), 64'(e.err));
          checkOutput("resp_id", 64'(resp_id), 64'(e.id));
        end
        exp_count = (exp_count + 1) % 65536;
      end
      hold_pending = resp_valid && !resp_ready;
      held = 64'({resp_valid, resp_flag, resp_err, resp_id, resp_data});
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        id_v = req1_valid && req1_ready;
        op_v = id_v ? req1_op : req0_op;
        a_v  = id_v ? req1_a : req0_a;
        b_v  = id_v ? req1_b : req0_b;
        if (op_v == 2'b11) begin
          e.data = 32'h7FC00000; e.flag = 1'b0; e.err = 1'b1;
          chk_op = 2'b00;
        end else begin
          r = dpModel(op_v, a_v, b_v);
          e.data = r[31:0]; e.flag = r[32]; e.err = 1'b0;
          chk_op = op_v;
        end
        e.id = id_v;
        exp_q.push_back(e);
        grant_log.push_back(id_v);
        chk_a = a_v;
        chk_b = b_v;
        chk_pending = 1'b1;
        accept_cyc = cyc;
      end
      prev_rv = resp_valid;
    end
  end

  task automatic applyStimulus(input logic id, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) done = 1'b1;
    end
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
    if (!done) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic waitDrain();
    bit drained;
    drained = 1'b0;
    for (int i = 0; i < 200 && !drained; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !resp_valid) drained = 1'b1;
    end
    if (!drained) checkOutput("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic checkResetValues();
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("rst_resp_data", 64'(resp_data), 64'd0);
    checkOutput("rst_resp_bits", 64'({resp_flag, resp_err, resp_id}), 64'd0);
    checkOutput("rst_fpu_op", 64'(fpu_op), 64'd0);
    checkOutput("rst_fpu_para", 64'({fpu_para1, fpu_para2}), 64'd0);
    checkOutput("rst_op_count", 64'(op_count), 64'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    rst = 1'b1; resp_ready = 1'b1;
    req0_valid = 1'b0; req0_op = 2'b00; req0_a = 32'd0; req0_b = 32'd0;
    req1_valid = 1'b0; req1_op = 2'b00; req1_a = 32'd0; req1_b = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetValues();
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vectors: add, sub, mul, overflow, illegal (last on req1 so req0 wins next tie).
    applyStimulus(1'b0, 2'b00, 32'h3F800000, 32'h40000000); waitDrain();
    checkOutput("count_after_add", 64'(op_count), 64'd1);
    applyStimulus(1'b1, 2'b01, 32'h40400000, 32'h3F800000); waitDrain();
    applyStimulus(1'b0, 2'b10, 32'h40000000, 32'h40400000); waitDrain();
    applyStimulus(1'b1, 2'b10, 32'h7F7FFFFF, 32'h40000000); waitDrain();
    applyStimulus(1'b1, 2'b11, $urandom, $urandom);          waitDrain();
    checkOutput("count_after_directed", 64'(op_count), 64'd5);

    // Both requesters contend continuously for four ops.
    grant_log.delete();
    fork
      begin
        for (int k = 0; k < 2; k++) applyStimulus(1'b0, 2'($urandom_range(0, 2)), $urandom, $urandom);
      end
      begin
        for (int k = 0; k < 2; k++) applyStimulus(1'b1, 2'($urandom_range(0, 2)), $urandom, $urandom);
      end
    join
    waitDrain();
    checkOutput("grant_count", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      checkOutput($sformatf("grant_order%0d", i), 64'(grant_log[i]), 64'(i % 2));
    checkOutput("count_after_arb", 64'(op_count), 64'd9);

    // Back-pressure: response must stay put while the consumer stalls.
    resp_ready = 1'b0;
    applyStimulus(1'b0, 2'b10, 32'h40000000, 32'h40400000);
    for (int i = 0; i < 50 && !resp_valid; i++) @(negedge clk);
    checkOutput("bp_resp_valid", 64'(resp_valid), 64'd1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    waitDrain();
    checkOutput("count_after_bp", 64'(op_count), 64'd10);

    // Reset in the middle of EXEC abandons the op.
    applyStimulus(1'b1, 2'b10, 32'h40000000, 32'h40400000);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkResetValues();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("no_resp_after_rst", 64'(resp_valid), 64'd0);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_arbiter_ctrl.md
# fpu_arbiter_ctrl

Sequencing and arbitration controller that shares one floating-point datapath (add, sub and multiply units on IEEE-754 single precision) between two requesters. It grants requests round-robin and registers operands onto the shared datapath inputs. After a fixed settle window it captures the combinational result and under/overflow flag, and returns them on a valid/ready response channel tagged with the requester ID. It sits between the instruction-issue logic and the FP ALU units, replacing direct per-client wiring.

## Interface
- SETTLE_CYCLES, 2, cycles the datapath is given to settle before capture; legal 1..15.
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  request present from client 0 / 1.
- req0_ready / req1_ready  out  1  request accepted this cycle when valid & ready.
- req0_op / req1_op  in  2  00 add, 01 sub (a−b), 10 mul, 11 illegal.
- req0_a, req0_b / req1_a, req1_b  in  32  operands.
- fpu_op  out  2  selects add/sub/mul result on the shared datapath.
- fpu_para1, fpu_para2  out  32  registered operands to the datapath.
- fpu_out  in  32  datapath result for fpu_op.
- fpu_under_overflow  in  1  datapath under/overflow flag.
- resp_valid  out  1  response held until accepted.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  32  captured result.
- resp_flag  out  1  captured under/overflow.
- resp_err  out  1  request carried an illegal op.
- resp_id  out  1  requester that issued the op.
- op_count  out  16  responses completed since reset.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - The arbiter picks one valid requester. If only one is valid, that one is picked.
  - If both are valid, the one not granted last is picked. last_grant resets to 1, so req0 wins first.
  - readyN = (state==IDLE) & granted==N. Ready is combinational from state, the valids and last_grant. At most one ready is high at a time.
  - On accept: register op/a/b onto fpu_op/fpu_para1/fpu_para2, latch id, update last_grant, load the settle counter with SETTLE_CYCLES−1, and go to EXEC.
- EXEC: the counter decrements each cycle. When the counter is 0, resp_data ← fpu_out and resp_flag ← fpu_under_overflow are captured, and the FSM goes to DONE.
- Illegal op (11):
  - Same path and latency as a legal op.
  - fpu_op is driven 00.
  - Captured values: resp_data=32'h7FC00000, resp_flag=0, resp_err=1.
- DONE: resp_valid=1; data, flag, err and id are stable. On resp_ready, go to IDLE and increment op_count; op_count wraps FFFF→0000.
- fpu_op/fpu_para1/fpu_para2 hold their value from accept until the next accept, including while idle.
- No request queue: a requester not granted keeps valid high and is served later. Deasserting valid before the grant is allowed.

## Timing
- Reset values:
  - state IDLE; req0_ready/req1_ready follow the IDLE rule, so either may be high in the first cycle after reset.
  - resp_valid, resp_data, resp_flag, resp_err, resp_id, fpu_op, fpu_para1, fpu_para2, op_count: all 0.
  - last_grant=1.
- Latency: accept at edge T, capture at edge T+SETTLE_CYCLES, resp_valid high from T+SETTLE_CYCLES (after that edge).
- With resp_ready tied high, resp_valid lasts 1 cycle and the next accept is possible 1 cycle later. Peak throughput is one op per SETTLE_CYCLES+2 cycles.
- Back-pressure: resp_ready low holds the FSM in DONE indefinitely, with both req ready outputs low.
- Simultaneous valids in IDLE resolve in the same cycle with no bubble. Grants strictly alternate while both stay valid.
- rst asserted in any state, including EXEC or DONE, abandons the op: no response is emitted, op_count is cleared, and the reset values apply on the next edge.

## Test plan
- Single add, SETTLE_CYCLES=2: req0 op=00, a=3F800000, b=40000000 → resp_data=40400000, flag=0, id=0, resp_valid 2 cycles after accept, op_count=1.
- Sub and mul:
  - req1 op=01, 40400000−3F800000 → 40000000, id=1.
  - op=10, 40000000×40400000 → 40C00000.
- Overflow: op=10, 7F7FFFFF×40000000 → resp_flag=1; illegal op=11 → resp_data=7FC00000, resp_err=1, flag=0, same latency.
- Arbitration: both valid continuously for 4 ops → grant order 0,1,0,1; never both ready; resp_id matches; op_count=4.
- Back-pressure and reset: hold resp_ready=0 for 5 cycles → resp fields stable, no ready asserted. Then assert rst during EXEC of the next op → no response, all outputs at reset values, op_count=0.
